// File: rtl/lut_loader_2ch.sv
// Framed byte-stream loader: packs host bytes into DATA_WIDTH words for the LUT RAM write port.
// Latency: o_we one cycle after the final byte of each word; o_ready drops only in the DONE cycle or when i_en is low.
// Optional LUT_LOADER_CHECKSUM_EN adds a trailing CSUM byte (header+data+CSUM must sum to 8'h00).
module lut_loader_2ch #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_ready,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_waddr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam logic [1:0] LAST_B = 2'(BYTES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_H = 3'd1;
    localparam logic [2:0] S_ADDR_L = 3'd2;
    localparam logic [2:0] S_CNT_H  = 3'd3;
    localparam logic [2:0] S_CNT_L  = 3'd4;
    localparam logic [2:0] S_DATA   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
`ifdef LUT_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd7;
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

    logic [2:0]            state_q;
    logic [7:0]            hdr_q;
    logic [15:0]           cnt_q;
    logic [1:0]            bidx_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic [DATA_WIDTH-1:0] word;
    logic                  xfer;
    logic                  last_byte;
`ifdef LUT_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q;
`endif

    assign o_ready   = i_rst_n && i_en && (state_q != S_DONE);
    assign xfer      = i_valid && o_ready;
    assign word      = DATA_WIDTH'({pack_q, i_byte});
    assign last_byte = (bidx_q == LAST_B);
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = (state_q == S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            hdr_q   <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            pack_q  <= '0;
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
            o_err   <= 1'b0;
`ifdef LUT_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            o_we <= 1'b0;
            // Address advances after the write cycle so o_waddr is stable while o_we is high.
            if (o_we)
                o_waddr <= o_waddr + ADDR_WIDTH'(1);
`ifdef LUT_LOADER_CHECKSUM_EN
            if (xfer && state_q != S_IDLE)
                sum_q <= sum_q + i_byte;
`endif
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        if (i_byte == SYNC_BYTE) begin
                            o_err   <= 1'b0;
                            bidx_q  <= '0;
                            state_q <= S_ADDR_H;
`ifdef LUT_LOADER_CHECKSUM_EN
                            sum_q   <= '0;
`endif
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                S_ADDR_H: if (xfer) begin
                    hdr_q   <= i_byte;
                    state_q <= S_ADDR_L;
                end
                S_ADDR_L: if (xfer) begin
                    o_waddr <= ADDR_WIDTH'({hdr_q, i_byte});
                    state_q <= S_CNT_H;
                end
                S_CNT_H: if (xfer) begin
                    hdr_q   <= i_byte;
                    state_q <= S_CNT_L;
                end
                S_CNT_L: if (xfer) begin
                    cnt_q   <= {hdr_q, i_byte};
                    state_q <= S_DATA;
                end
                S_DATA: if (xfer) begin
                    pack_q <= word;
                    if (last_byte) begin
                        bidx_q  <= '0;
                        o_we    <= 1'b1;
                        o_wdata <= word;
                        if (cnt_q == 16'd0)
                            state_q <= S_AFTER_DATA;
                        else
                            cnt_q <= cnt_q - 16'd1;
                    end else begin
                        bidx_q <= bidx_q + 2'd1;
                    end
                end
`ifdef LUT_LOADER_CHECKSUM_EN
                S_CSUM: if (xfer) begin
                    if (8'(sum_q + i_byte) == 8'h00) begin
                        state_q <= S_DONE;
                    end else begin
                        o_err   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
`endif
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
